// File: rtl/cactus_pkg.sv
// Shared types and constants for the cactus generator and its neighbours.
// Contents: FSM state enum, cactus type enum, per-type height/width tables,
// default screen geometry, and a type-to-dimensions lookup helper.
package cactus_pkg;

  localparam int unsigned SCREEN_W_DEF = 320;
  localparam int unsigned GROUND_Y_DEF = 240;
  localparam int unsigned X_W          = 9;
  localparam int unsigned DIM_W        = 6;
  localparam int unsigned SPD_W        = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SMALL  = 2'd0,
    TALL   = 2'd1,
    WIDE   = 2'd2,
    DOUBLE = 2'd3
  } cactus_type_t;

  typedef struct packed {
    logic [DIM_W-1:0] height;
    logic [DIM_W-1:0] width;
  } cactus_dim_t;

  // Indexed by cactus_type_t: element [0] is SMALL.
  localparam logic [3:0][DIM_W-1:0] HEIGHT_TBL = {6'd40, 6'd24, 6'd32, 6'd16};
  localparam logic [3:0][DIM_W-1:0] WIDTH_TBL  = {6'd12, 6'd20, 6'd10, 6'd8};

  function automatic cactus_dim_t cactus_dim(input cactus_type_t t);
    cactus_dim_t d;
    d.height = HEIGHT_TBL[t];
    d.width  = WIDTH_TBL[t];
    return d;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, free-running.
// Ports: clk, reset (sync active-low, loads seed), seed[7:0], out[7:0].
// Reusable by the floor and cloud generators.
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Taps 8,6,5,4 map to bits 7,5,4,3 with a left shift.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/cactus_generator.sv
// Cactus obstacle generator: spawns one pseudo-random cactus at the right
// screen edge, scrolls it left on each frame step, then waits a random gap.
// Ports: clk, reset (sync active-low), en, step, freeze, speed[2:0];
// outputs cactusX/cactusY[8:0], cactusHeight/cactusWidth[5:0],
// cactus_valid, cactus_passed (one-cycle pulse). All outputs registered.
// Optional macro CACTUS_SPEED_RAMP_EN: use an internal speed register that
// ramps after every 8th passed cactus instead of the speed port.
module cactus_generator
  import cactus_pkg::*;
#(
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned GROUND_Y  = GROUND_Y_DEF,
  parameter int unsigned MIN_GAP   = 20,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             step,
  input  logic             freeze,
  input  logic [SPD_W-1:0] speed,
  output logic [X_W-1:0]   cactusX,
  output logic [X_W-1:0]   cactusY,
  output logic [DIM_W-1:0] cactusHeight,
  output logic [DIM_W-1:0] cactusWidth,
  output logic             cactus_valid,
  output logic             cactus_passed
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP + 16);
  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W - 1);
  localparam cactus_dim_t RST_DIM = '{height: 6'd16, width: 6'd8};

  state_t             state_q, state_d;
  cactus_type_t       type_q, type_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [X_W-1:0]     y_q, y_d;
  logic [DIM_W-1:0]   h_q, h_d;
  logic [DIM_W-1:0]   w_q, w_d;
  logic               valid_q, valid_d;
  logic               passed_q, passed_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [7:0]         lfsr;
  logic [SPD_W-1:0]   eff_speed;
  logic [X_W-1:0]     spd9_c;
  cactus_dim_t        dim_c;
  logic               unused_lfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:6];

`ifdef CACTUS_SPEED_RAMP_EN
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [2:0]       pass_cnt_q, pass_cnt_d;
  logic             unused_speed;

  assign unused_speed = ^speed;
  assign eff_speed    = spd_q;

  // Bump speed on every 8th passed cactus, saturating at 7; en=0 resets it.
  always_comb begin
    spd_d      = spd_q;
    pass_cnt_d = pass_cnt_q;
    if (!en) begin
      spd_d      = SPD_W'(1);
      pass_cnt_d = 3'd0;
    end else if (passed_d) begin
      pass_cnt_d = pass_cnt_q + 3'd1;
      if ((pass_cnt_q == 3'd7) && (spd_q != SPD_W'(7))) begin
        spd_d = spd_q + SPD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      spd_q      <= SPD_W'(1);
      pass_cnt_q <= 3'd0;
    end else begin
      spd_q      <= spd_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end
`else
  assign eff_speed = speed;
`endif

  // Speed 0 behaves as 1 so the cactus always makes progress.
  always_comb begin
    spd9_c = (eff_speed == '0) ? X_W'(1) : X_W'(eff_speed);
  end

  always_comb begin
    dim_c = cactus_dim(cactus_type_t'(lfsr[1:0]));
  end

  // Next-state and output logic; en=0 beats freeze, freeze beats step.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    x_d      = x_q;
    y_d      = y_q;
    h_d      = h_q;
    w_d      = w_q;
    valid_d  = valid_q;
    passed_d = 1'b0;
    gap_d    = gap_q;

    if (!en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      x_d     = SPAWN_X;
    end else if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          state_d = GAP;
          gap_d   = GAP_W'(MIN_GAP);
        end
        GAP: begin
          if (step) begin
            if (gap_q == '0) begin
              type_d  = cactus_type_t'(lfsr[1:0]);
              h_d     = dim_c.height;
              w_d     = dim_c.width;
              y_d     = X_W'(GROUND_Y) - X_W'(dim_c.height);
              x_d     = SPAWN_X;
              valid_d = 1'b1;
              state_d = ACTIVE;
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (step) begin
            if (x_q >= spd9_c) begin
              x_d = x_q - spd9_c;
            end else begin
              x_d      = SPAWN_X;
              valid_d  = 1'b0;
              passed_d = 1'b1;
              gap_d    = GAP_W'(MIN_GAP) + GAP_W'(lfsr[5:2]);
              state_d  = GAP;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      type_q   <= SMALL;
      x_q      <= SPAWN_X;
      h_q      <= RST_DIM.height;
      w_q      <= RST_DIM.width;
      y_q      <= X_W'(GROUND_Y) - X_W'(RST_DIM.height);
      valid_q  <= 1'b0;
      passed_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      x_q      <= x_d;
      h_q      <= h_d;
      w_q      <= w_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      passed_q <= passed_d;
      gap_q    <= gap_d;
    end
  end

  assign cactusX       = x_q;
  assign cactusY       = y_q;
  assign cactusHeight  = h_q;
  assign cactusWidth   = w_q;
  assign cactus_valid  = valid_q;
  assign cactus_passed = passed_q;

endmodule
